// File: rtl/mc_ctrl_if.sv
// Memory handshake between the multi-cycle controller and the shared instruction/data memory.
// The controller issues requests and the memory answers with mem_ready.
interface mc_ctrl_if;
  logic mem_req;
  logic IorD;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output IorD, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input IorD, input MemWrite, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXE/MEM/WB with a memory ready handshake,
// datapath selects, PC/IR/RF strobes and a retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  mc_ctrl_if.master        mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             EXTOp,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             ALUSrc,
  output logic             AregSel,
  output logic             GPRSel,
  output logic             WDSel,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8
  } alu_op_t;

  state_t  cur_state, next_state;
  alu_op_t dec_alu_op;
  logic    dec_legal, dec_r, dec_j, dec_jr, dec_beq, dec_bne, dec_lw, dec_sw;
  logic    dec_src, dec_ext, dec_areg;
  logic    taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      instret   <= '0;
    end else begin
      cur_state <= next_state;
      if (instr_done)
        instret <= instret + CNT_W'(1);
    end
  end

  assign state = cur_state;
  assign taken = (dec_beq & Zero) | (dec_bne & ~Zero);

  // Instruction classification and the ALU selects it implies, held from EXE through WB
  always_comb begin
    dec_legal  = 1'b1;
    dec_r      = 1'b0;
    dec_j      = 1'b0;
    dec_jr     = 1'b0;
    dec_beq    = 1'b0;
    dec_bne    = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_src    = 1'b0;
    dec_ext    = 1'b0;
    dec_areg   = 1'b0;
    dec_alu_op = ALU_NOP;
    case (Op)
      6'b000000: begin
        dec_r = 1'b1;
        case (Funct)
          6'b100000, 6'b100001: dec_alu_op = ALU_ADD;
          6'b100010, 6'b100011: dec_alu_op = ALU_SUB;
          6'b100100:            dec_alu_op = ALU_AND;
          6'b100101:            dec_alu_op = ALU_OR;
          6'b101010:            dec_alu_op = ALU_SLT;
          6'b000000: begin dec_alu_op = ALU_SLL; dec_areg = 1'b1; end
          6'b000010: begin dec_alu_op = ALU_SRL; dec_areg = 1'b1; end
          6'b001000:            dec_jr = 1'b1;
          default:              dec_legal = 1'b0;
        endcase
      end
      6'b001000, 6'b001001: begin dec_alu_op = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'b001100: begin dec_alu_op = ALU_AND; dec_src = 1'b1; end
      6'b001101: begin dec_alu_op = ALU_OR;  dec_src = 1'b1; end
      6'b001111: begin dec_alu_op = ALU_LUI; dec_src = 1'b1; end
      6'b100011: begin dec_alu_op = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; dec_lw = 1'b1; end
      6'b101011: begin dec_alu_op = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; dec_sw = 1'b1; end
      6'b000100: begin dec_alu_op = ALU_SUB; dec_ext = 1'b1; dec_beq = 1'b1; end
      6'b000101: begin dec_alu_op = ALU_SUB; dec_ext = 1'b1; dec_bne = 1'b1; end
      6'b000010: dec_j = 1'b1;
      default:   dec_legal = 1'b0;
    endcase
  end

  // Next state and strobes; reset overrides everything so an aborted instruction has no side effects
  always_comb begin
    next_state   = cur_state;
    mem.mem_req  = 1'b0;
    mem.IorD     = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    EXTOp        = 1'b0;
    ALUOp        = ALU_NOP;
    NPCOp        = 2'b00;
    ALUSrc       = 1'b0;
    AregSel      = 1'b0;
    GPRSel       = 1'b0;
    WDSel        = 1'b0;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    if (cur_state == S_EXE || cur_state == S_MEM || cur_state == S_WB) begin
      EXTOp   = dec_ext;
      ALUOp   = dec_alu_op;
      ALUSrc  = dec_src;
      AregSel = dec_areg;
    end
    case (cur_state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          IRWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_legal || dec_j || dec_jr) begin
          illegal    = ~dec_legal;
          PCWrite    = 1'b1;
          NPCOp      = !dec_legal ? 2'b00 : (dec_j ? 2'b10 : 2'b11);
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (dec_beq || dec_bne) begin
          PCWrite    = 1'b1;
          NPCOp      = {1'b0, taken};
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (dec_lw || dec_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.IorD     = 1'b1;
        mem.MemWrite = dec_sw;
        if (mem.mem_ready) begin
          if (dec_sw) begin
            PCWrite    = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        GPRSel     = ~dec_r;
        WDSel      = dec_lw;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    if (rst) begin
      mem.mem_req  = 1'b0;
      mem.IorD     = 1'b0;
      mem.MemWrite = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      EXTOp        = 1'b0;
      ALUOp        = ALU_NOP;
      NPCOp        = 2'b00;
      ALUSrc       = 1'b0;
      AregSel      = 1'b0;
      GPRSel       = 1'b0;
      WDSel        = 1'b0;
      illegal      = 1'b0;
      instr_done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// compares every control output against hand-computed values.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc, AregSel, GPRSel, WDSel;
  logic       illegal, instr_done;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp;
  logic [3:0] instret;
  logic [2:0] state;
  int         vectors = 0;
  int         miscompares = 0;

  mc_ctrl_if mem_bus();

  mc_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(mem_bus),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc), .AregSel(AregSel),
    .GPRSel(GPRSel), .WDSel(WDSel), .illegal(illegal), .instr_done(instr_done),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Field order: state, mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp,
  // ALUOp, NPCOp, ALUSrc, AregSel, GPRSel, WDSel, illegal, instr_done
  task automatic exp_cyc(input string tag, input logic [2:0] st,
                         input logic mreq, iord, mw, irw, pcw, rw, ext,
                         input logic [3:0] aop, input logic [1:0] npc,
                         input logic src, areg, gpr, wd, ill, done);
    logic [31:0] obs, exp;
    #1;
    obs = {10'd0, state, mem_bus.mem_req, mem_bus.IorD, mem_bus.MemWrite, IRWrite, PCWrite,
           RegWrite, EXTOp, ALUOp, NPCOp, ALUSrc, AregSel, GPRSel, WDSel, illegal, instr_done};
    exp = {10'd0, st, mreq, iord, mw, irw, pcw, rw, ext, aop, npc, src, areg, gpr, wd, ill, done};
    check(tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_bus.mem_ready = 1'b1;
    step();
    exp_cyc("reset_outputs", 3'd0, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0);
    check("reset_instret", 32'(instret), 32'd0);
    step();
    rst = 1'b0;

    // addu $3,$1,$2: FETCH, DECODE, EXE, WB
    Op = 6'b000000; Funct = 6'b100001;
    exp_cyc("addu_fetch",  3'd0, 1,0,0,1,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("addu_decode", 3'd1, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("addu_exe",    3'd2, 0,0,0,0,0,0,0, 4'd1, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("addu_wb",     3'd4, 0,0,0,0,1,1,0, 4'd1, 2'd0, 0,0,0,0,0,1); step();
    exp_cyc("addu_after",  3'd0, 1,0,0,1,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0);
    check("addu_instret", 32'(instret), 32'd1);

    // lw with two wait cycles in MEM: 7 cycles total
    Op = 6'b100011;
    exp_cyc("lw_fetch",  3'd0, 1,0,0,1,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("lw_decode", 3'd1, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("lw_exe",    3'd2, 0,0,0,0,0,0,1, 4'd1, 2'd0, 1,0,0,0,0,0); step();
    mem_bus.mem_ready = 1'b0;
    exp_cyc("lw_mem_w1", 3'd3, 1,1,0,0,0,0,1, 4'd1, 2'd0, 1,0,0,0,0,0); step();
    exp_cyc("lw_mem_w2", 3'd3, 1,1,0,0,0,0,1, 4'd1, 2'd0, 1,0,0,0,0,0); step();
    mem_bus.mem_ready = 1'b1;
    exp_cyc("lw_mem_ok", 3'd3, 1,1,0,0,0,0,1, 4'd1, 2'd0, 1,0,0,0,0,0); step();
    exp_cyc("lw_wb",     3'd4, 0,0,0,0,1,1,1, 4'd1, 2'd0, 1,0,1,1,0,1); step();
    check("lw_instret", 32'(instret), 32'd2);

    // beq/bne with both Zero values, first one with a FETCH stall
    Op = 6'b000100; Zero = 1'b1; mem_bus.mem_ready = 1'b0;
    exp_cyc("beq_fetch_stall", 3'd0, 1,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    mem_bus.mem_ready = 1'b1;
    exp_cyc("beq_fetch", 3'd0, 1,0,0,1,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("beq_decode", 3'd1, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("beq_z1_exe", 3'd2, 0,0,0,0,1,0,1, 4'd2, 2'd1, 0,0,0,0,0,1); step();
    Zero = 1'b0;
    step(); step();
    exp_cyc("beq_z0_exe", 3'd2, 0,0,0,0,1,0,1, 4'd2, 2'd0, 0,0,0,0,0,1); step();
    Op = 6'b000101;
    step(); step();
    exp_cyc("bne_z0_exe", 3'd2, 0,0,0,0,1,0,1, 4'd2, 2'd1, 0,0,0,0,0,1); step();
    Zero = 1'b1;
    step(); step();
    exp_cyc("bne_z1_exe", 3'd2, 0,0,0,0,1,0,1, 4'd2, 2'd0, 0,0,0,0,0,1); step();
    check("branch_instret", 32'(instret), 32'd6);
    Zero = 1'b0;

    // sw: MEM writes and retires, no WB
    Op = 6'b101011;
    step(); step();
    exp_cyc("sw_exe", 3'd2, 0,0,0,0,0,0,1, 4'd1, 2'd0, 1,0,0,0,0,0); step();
    exp_cyc("sw_mem", 3'd3, 1,1,1,0,1,0,1, 4'd1, 2'd0, 1,0,0,0,0,1); step();
    exp_cyc("sw_next_fetch", 3'd0, 1,0,0,1,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0);

    // j, jr and an unsupported opcode all retire in DECODE
    Op = 6'b000010;
    step();
    exp_cyc("j_decode", 3'd1, 0,0,0,0,1,0,0, 4'd0, 2'd2, 0,0,0,0,0,1); step();
    Op = 6'b000000; Funct = 6'b001000;
    step();
    exp_cyc("jr_decode", 3'd1, 0,0,0,0,1,0,0, 4'd0, 2'd3, 0,0,0,0,0,1); step();
    Op = 6'b111111;
    step();
    exp_cyc("illegal_decode", 3'd1, 0,0,0,0,1,0,0, 4'd0, 2'd0, 0,0,0,0,1,1); step();
    check("jump_instret", 32'(instret), 32'd10);

    // sll uses shamt as ALU A; ori zero-extends and writes rt
    Op = 6'b000000; Funct = 6'b000000;
    step(); step();
    exp_cyc("sll_exe", 3'd2, 0,0,0,0,0,0,0, 4'd6, 2'd0, 0,1,0,0,0,0); step();
    exp_cyc("sll_wb",  3'd4, 0,0,0,0,1,1,0, 4'd6, 2'd0, 0,1,0,0,0,1); step();
    Op = 6'b001101;
    step(); step();
    exp_cyc("ori_exe", 3'd2, 0,0,0,0,0,0,0, 4'd4, 2'd0, 1,0,0,0,0,0); step();
    exp_cyc("ori_wb",  3'd4, 0,0,0,0,1,1,0, 4'd4, 2'd0, 1,0,1,0,0,1); step();
    check("alu_instret", 32'(instret), 32'd12);

    // Reset during MEM of a store aborts it
    Op = 6'b101011;
    step(); step(); step();
    rst = 1'b1;
    exp_cyc("sw_mem_reset", 3'd3, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0); step();
    exp_cyc("after_reset", 3'd0, 0,0,0,0,0,0,0, 4'd0, 2'd0, 0,0,0,0,0,0);
    check("after_reset_instret", 32'(instret), 32'd0);
    rst = 1'b0;

    // 15 jumps take the 4-bit counter to all-ones, the 16th wraps it
    Op = 6'b000010;
    for (int i = 0; i < 15; i++) begin
      step(); step();
    end
    check("instret_max", 32'(instret), 32'd15);
    step();
    exp_cyc("wrap_decode", 3'd1, 0,0,0,0,1,0,0, 4'd0, 2'd2, 0,0,0,0,0,1); step();
    check("instret_wrap", 32'(instret), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control sequencer that replaces the single-cycle decoder when the CPU moves to a shared-memory multi-cycle datapath. Steps each instruction through FETCH/DECODE/EXE/MEM/WB, stalling on a memory ready handshake. Emits the same datapath selects as the single-cycle controller, plus PC/IR write strobes, memory requests and a retired-instruction counter. Sits beside PC, RF, ALU, EXT and the muxes inside the multi-cycle CPU top.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
Op  in  6  opcode from instruction register (IR[31:26])
Funct  in  6  funct from IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request (instruction fetch or data access)
IorD  out  1  0 = address from PC, 1 = address from aluout
MemWrite  out  1  data store strobe, valid with mem_req
IRWrite  out  1  load IR from readdata
PCWrite  out  1  load PC from NPC
RegWrite  out  1  RF write enable
EXTOp  out  1  1 = sign extend, 0 = zero extend
ALUOp  out  4  ALU operation
NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr (RD1)
ALUSrc  out  1  ALU B: 0 = RD2, 1 = Imm32
AregSel  out  1  ALU A: 0 = RD1, 1 = shamt
GPRSel  out  1  write address: 0 = rd, 1 = rt
WDSel  out  1  write data: 0 = aluout, 1 = readdata
illegal  out  1  one-cycle pulse, unsupported Op/Funct in DECODE
instr_done  out  1  one-cycle pulse on instruction retire
instret  out  CNT_W  retired-instruction count
state  out  3  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Register updates on rising clk only.
- Reset: while rst=1, state<=FETCH and instret<=0. All strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal, instr_done) are forced 0, with selects 0. A reset mid-instruction aborts it with no PC/RF/memory side effects.
- Outputs are combinational in state, Op, Funct and Zero. Op/Funct must stay stable from DECODE onward.
- FETCH: mem_req=1, IorD=0. Stay while mem_ready=0. When mem_ready=1: IRWrite=1, then go to DECODE.
- DECODE: no strobes.
  - j: PCWrite=1, NPCOp=10, retire, go to FETCH.
  - R-type jr (Funct 001000): PCWrite=1, NPCOp=11, retire, go to FETCH.
  - Unsupported code: illegal=1, PCWrite=1, NPCOp=00, retire, go to FETCH.
  - Otherwise go to EXE.
- Supported codes:
  - R-type, Funct: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000.
  - I-type, Op: addi 001000, addiu 001001, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- ALUOp encoding: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLL=6, SRL=7, LUI=8.
- EXE: ALU selects are driven.
  - R-type: ALUSrc=0. AregSel=1 for sll/srl, else 0.
  - addi/addiu/lw/sw: ALUSrc=1, EXTOp=1, ALUOp=ADD.
  - andi/ori: ALUSrc=1, EXTOp=0.
  - lui: ALUSrc=1, ALUOp=LUI.
  - beq/bne: ALUOp=SUB, ALUSrc=0, EXTOp=1, PCWrite=1. Taken if beq&Zero or bne&~Zero; taken gives NPCOp=01, not taken gives 00. Retire, go to FETCH.
  - lw/sw go to MEM; the others go to WB.
- MEM: mem_req=1, IorD=1, MemWrite=1 for sw, 0 for lw. ALU selects are held as in EXE so aluout stays stable. Stay while mem_ready=0.
  - sw on ready: PCWrite=1, NPCOp=00, retire, go to FETCH.
  - lw on ready: go to WB.
- WB: RegWrite=1, PCWrite=1, NPCOp=00, retire, go to FETCH. ALU selects are held.
  - R-type: GPRSel=0, WDSel=0.
  - I-ALU: GPRSel=1, WDSel=0.
  - lw: GPRSel=1, WDSel=1; readdata is held by memory until the next request.
- Retire: instr_done=1 for exactly one cycle, coincident with the PCWrite that ends the instruction. instret increments by 1 in the same edge and wraps modulo 2^CNT_W.
- Latencies with mem_ready always 1 (cycles): j/jr/illegal 2, beq/bne 3, R/I-ALU 4, sw 4, lw 5. Each extra cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- mem_ready outside FETCH/MEM is ignored.
- PCWrite and RegWrite are never both asserted in any state except WB.
- MemWrite is never asserted without mem_req.

Test Plan:
- Reset then release, mem_ready=1, IR=addu $3,$1,$2 -> states 0,1,2,4,0. RegWrite=1 only in WB with GPRSel=0. instr_done pulses once; instret=1.
- lw with mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles, IorD=1, MemWrite=0. WB has WDSel=1, GPRSel=1. Total 7 cycles.
- beq with Zero=1 -> EXE PCWrite=1, NPCOp=01. With Zero=0 -> NPCOp=00. bne inverts. Both take 3 cycles; RegWrite never asserted.
- sw -> MEM MemWrite=1, mem_req=1, no WB. j -> PCWrite in DECODE, NPCOp=10. jr -> NPCOp=11. Each retires once.
- Op=111111 -> illegal pulse in DECODE, PC+4, instret+1. rst asserted in MEM of sw -> MemWrite=0 that cycle, next state FETCH, instret=0.
- Preload instret near all-ones via 2^CNT_W-1 retires (CNT_W=4: 15 instrs) -> next retire gives instret=0.
